// File: rtl/prog_clk_divider_if.sv
// Control/status bundle of the programmable feedback divider.
// The master side drives the ratio requests; the slave side is the divider itself.
interface prog_clk_divider_if #(
   parameter int WIDTH = 8
);
   logic             enable;
   logic [WIDTH-1:0] div_val;
   logic             div_load;
   logic             clk_out;
   logic             fb_tick;
   logic [WIDTH-1:0] div_cur;
   logic             load_ack;
   logic             div_err;

   modport master (
      output enable, div_val, div_load,
      input  clk_out, fb_tick, div_cur, load_ack, div_err
   );

   modport slave (
      input  enable, div_val, div_load,
      output clk_out, fb_tick, div_cur, load_ack, div_err
   );
endinterface

// File: rtl/prog_clk_divider.sv
// Programmable integer divider for the PLL feedback path. Ratio changes are
// shadowed and applied only on a period boundary, so clk_out never glitches.
module prog_clk_divider #(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 10
) (
   input  logic                 clk_in,
   input  logic                 rst_n,
   prog_clk_divider_if.slave    bus
);
   localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] div_cur_q, div_cur_d;
   logic [WIDTH-1:0] pend_val_q, pend_val_d;
   logic             pend_q, pend_d;
   logic             clk_out_q, clk_out_d;
   logic             fb_tick_q, fb_tick_d;
   logic             load_ack_q, load_ack_d;
   logic             div_err_q, div_err_d;

   logic [WIDTH-1:0] last_cnt;
   logic [WIDTH-1:0] cnt_inc;
   logic [WIDTH-1:0] high_len;
   logic             boundary;

   always_comb begin
      last_cnt = div_cur_q - ONE;
      cnt_inc  = cnt_q + ONE;
      high_len = div_cur_q - (div_cur_q >> 1);
      // >= rather than == keeps the counter self-recovering from any stray value
      boundary = (cnt_q >= last_cnt);

      cnt_d      = cnt_q;
      div_cur_d  = div_cur_q;
      pend_val_d = pend_val_q;
      pend_d     = pend_q;
      clk_out_d  = clk_out_q;
      fb_tick_d  = 1'b0;
      load_ack_d = 1'b0;
      div_err_d  = div_err_q;

      if (bus.enable) begin
         if (boundary) begin
            cnt_d     = '0;
            clk_out_d = 1'b1;
            fb_tick_d = 1'b1;
            if (pend_q) begin
               div_cur_d  = pend_val_q;
               load_ack_d = 1'b1;
               pend_d     = 1'b0;
            end
         end else begin
            cnt_d     = cnt_inc;
            clk_out_d = (cnt_inc < high_len);
         end
      end

      // A load arriving on a boundary edge lands in the shadow after the
      // boundary consumed the old one, so it waits for the next boundary.
      if (bus.div_load) begin
         if (bus.div_val < TWO) begin
            div_err_d = 1'b1;
         end else begin
            pend_val_d = bus.div_val;
            pend_d     = 1'b1;
            div_err_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= DEF_DIV - ONE;
         div_cur_q  <= DEF_DIV;
         pend_val_q <= DEF_DIV;
         pend_q     <= 1'b0;
         clk_out_q  <= 1'b0;
         fb_tick_q  <= 1'b0;
         load_ack_q <= 1'b0;
         div_err_q  <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         div_cur_q  <= div_cur_d;
         pend_val_q <= pend_val_d;
         pend_q     <= pend_d;
         clk_out_q  <= clk_out_d;
         fb_tick_q  <= fb_tick_d;
         load_ack_q <= load_ack_d;
         div_err_q  <= div_err_d;
      end
   end

   assign bus.clk_out  = clk_out_q;
   assign bus.fb_tick  = fb_tick_q;
   assign bus.div_cur  = div_cur_q;
   assign bus.load_ack = load_ack_q;
   assign bus.div_err  = div_err_q;
endmodule

// File: tb/tb_prog_clk_divider.sv
// Bench for prog_clk_divider: directed scenarios with literal expectations plus
// a randomized run checked every cycle against a waveform-queue model.
module tb_prog_clk_divider;
   localparam int WIDTH = 8;
   localparam int DEF   = 10;

   logic clk_in = 1'b0;
   logic rst_n  = 1'b0;
   int   total  = 0;
   int   bad    = 0;

   prog_clk_divider_if #(.WIDTH(WIDTH)) bus ();

   prog_clk_divider #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF)) dut (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
      end
   endtask

   // Model: each period is a list of per-cycle values (2 = first high cycle
   // with tick, 1 = high, 0 = low). An enabled edge with an empty list is a
   // boundary; the next period's list is built then, after applying any
   // pending ratio.
   int m_wave[$];
   int m_cur  = DEF;
   int m_pval = DEF;
   bit m_pend = 0;
   bit m_err  = 0;
   bit m_clk  = 0;
   bit m_tick = 0;
   bit m_ack  = 0;

   always @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         m_wave.delete();
         m_cur = DEF; m_pval = DEF; m_pend = 0; m_err = 0;
         m_clk = 0; m_tick = 0; m_ack = 0;
      end else begin
         int v;
         m_tick = 0;
         m_ack  = 0;
         if (bus.enable) begin
            if (m_wave.size() == 0) begin
               if (m_pend) begin
                  m_cur  = m_pval;
                  m_pend = 0;
                  m_ack  = 1;
               end
               for (int i = 0; i < m_cur; i++)
                  m_wave.push_back(i == 0 ? 2 : (i < m_cur - m_cur / 2) ? 1 : 0);
            end
            v      = m_wave.pop_front();
            m_clk  = (v != 0);
            m_tick = (v == 2);
         end
         if (bus.div_load) begin
            if (int'(bus.div_val) < 2) m_err = 1;
            else begin
               m_pval = int'(bus.div_val);
               m_pend = 1;
               m_err  = 0;
            end
         end
      end
   end

   always @(posedge clk_in) begin
      #2;
      chk("model_clk_out",  int'(bus.clk_out),  int'(m_clk));
      chk("model_fb_tick",  int'(bus.fb_tick),  int'(m_tick));
      chk("model_div_cur",  int'(bus.div_cur),  m_cur);
      chk("model_load_ack", int'(bus.load_ack), int'(m_ack));
      chk("model_div_err",  int'(bus.div_err),  int'(m_err));
   end

   task automatic tick();
      @(posedge clk_in);
      #3;
   endtask

   task automatic load(input int val);
      bus.div_load = 1'b1;
      bus.div_val  = WIDTH'(val);
      tick();
      bus.div_load = 1'b0;
   endtask

   // Reset, release, and take the first (boundary) edge.
   task automatic restart();
      rst_n = 1'b0; bus.enable = 1'b0; bus.div_load = 1'b0;
      tick();
      rst_n = 1'b1; bus.enable = 1'b1;
      tick();
   endtask

   task automatic wait_ack(input string name, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!bus.load_ack && n < 40);
      chk(name, int'(bus.load_ack), 1);
   endtask

   initial begin
      int hi, ft, n, len, acks;
      bus.enable = 1'b0; bus.div_load = 1'b0; bus.div_val = '0;
      repeat (2) tick();
      chk("rst_clk_out", int'(bus.clk_out), 0);
      chk("rst_div_cur", int'(bus.div_cur), 10);
      chk("rst_fb_tick", int'(bus.fb_tick), 0);
      chk("rst_div_err", int'(bus.div_err), 0);

      // Default ratio: first edge is a boundary, then 5 high / 5 low.
      rst_n = 1'b1; bus.enable = 1'b1;
      tick();
      chk("first_clk_out", int'(bus.clk_out), 1);
      chk("first_fb_tick", int'(bus.fb_tick), 1);
      hi = 1; ft = 1;
      repeat (9) begin tick(); hi += int'(bus.clk_out); ft += int'(bus.fb_tick); end
      chk("div10_high", hi, 5);
      repeat (10) begin tick(); ft += int'(bus.fb_tick); end
      chk("div10_ticks_20cyc", ft, 2);

      // Load 7 while cnt=3: current period completes, then 4 high / 3 low.
      repeat (4) tick();
      load(7);
      wait_ack("n7_ack", n);
      chk("n7_wait", n, 6);
      chk("n7_div_cur", int'(bus.div_cur), 7);
      chk("n7_clk_out", int'(bus.clk_out), 1);
      hi = 1;
      repeat (6) begin tick(); hi += int'(bus.clk_out); end
      chk("n7_high", hi, 4);
      tick();
      chk("n7_next_tick", int'(bus.fb_tick), 1);
      chk("n7_no_ack", int'(bus.load_ack), 0);

      // Illegal load sets the sticky error; a legal one clears it.
      restart();
      load(1);
      chk("ld1_err", int'(bus.div_err), 1);
      chk("ld1_cur", int'(bus.div_cur), 10);
      load(2);
      chk("ld2_err", int'(bus.div_err), 0);
      wait_ack("n2_ack", n);
      chk("n2_div_cur", int'(bus.div_cur), 2);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("n2_toggle", int'(bus.clk_out), i % 2 == 0 ? 0 : 1);
      end

      // Two loads in one period: last wins, single ack.
      restart();
      load(6);
      load(9);
      acks = 0;
      repeat (30) begin tick(); acks += int'(bus.load_ack); end
      chk("lww_acks", acks, 1);
      chk("lww_cur", int'(bus.div_cur), 9);

      // Enable low for 3 cycles in the high phase stretches the period.
      restart();
      len = 1; hi = int'(bus.clk_out);
      for (int i = 1; i < 40; i++) begin
         bus.enable = !(i >= 2 && i <= 4);
         tick();
         if (bus.fb_tick) break;
         len++;
         hi += int'(bus.clk_out);
      end
      bus.enable = 1'b1;
      chk("freeze_len", len, 13);
      chk("freeze_high", hi, 8);

      // Mid-period reset with a pending load and a raised error.
      restart();
      load(7);
      load(1);
      tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_clk_out", int'(bus.clk_out), 0);
      chk("midrst_div_cur", int'(bus.div_cur), 10);
      chk("midrst_div_err", int'(bus.div_err), 0);
      bus.enable = 1'b0;
      tick();
      rst_n = 1'b1; bus.enable = 1'b1;
      acks = 0;
      repeat (25) begin tick(); acks += int'(bus.load_ack); end
      chk("midrst_no_ack", acks, 0);
      chk("midrst_cur", int'(bus.div_cur), 10);

      // Randomized run against the model.
      for (int i = 0; i < 4000; i++) begin
         rst_n        = ($urandom_range(0, 299) != 0);
         bus.enable   = ($urandom_range(0, 7) != 0);
         bus.div_load = ($urandom_range(0, 5) == 0);
         case ($urandom_range(0, 7))
            0:       bus.div_val = WIDTH'($urandom_range(0, 1));
            1:       bus.div_val = WIDTH'($urandom_range(250, 255));
            default: bus.div_val = WIDTH'($urandom_range(2, 12));
         endcase
         tick();
      end
      rst_n = 1'b1;
      bus.div_load = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
